// File: rtl/pll_pkg.sv
// pll_pkg: shared constants and width helper for the clock generator.
// Holds default divider/lock settings and their legal upper bounds.
package pll_pkg;

    localparam int DEF_DIV         = 2;
    localparam int DEF_LOCK_CYCLES = 256;
    localparam int MAX_DIV         = 256;
    localparam int MAX_LOCK_CYCLES = 65535;

    // Counter width able to hold 0..n-1, never narrower than 1 bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_det.sv
// pll_lock_det: counts reference edges after reset release, raises sticky lock.
// Ports: clk_i reference clock, rst_ni sync active-low reset, lock_o flag.
module pll_lock_det
    import pll_pkg::*;
#(
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic lock_o
);

    localparam int LW = width_of(LOCK_CYCLES);
    localparam logic [LW-1:0] LAST = LW'(LOCK_CYCLES - 1);

    logic [LW-1:0] lock_cnt_q;
    logic [LW-1:0] lock_cnt_d;
    logic          lock_q;
    logic          lock_d;

    // Counter freezes on the lock edge; only reset can clear lock.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (!lock_q) begin
            if (lock_cnt_q == LAST) begin
                lock_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign lock_o = lock_q;

endmodule

// File: rtl/pll_clk_gen.sv
// pll_clk_gen: integer clock divider with duty/phase control and lock flag.
// Ports: clkin1 reference, rst_n sync active-low, clkout0 divided, lock valid.
module pll_clk_gen
    import pll_pkg::*;
#(
    parameter real CLKIN_FREQ  = 27.0,
    parameter int  DIV         = DEF_DIV,
    parameter int  HIGH_CYCLES = DIV / 2,
    parameter int  PHASE       = 0,
    parameter int  LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic clkin1,
    input  logic rst_n,
    output logic clkout0,
    output logic lock
);

    if (CLKIN_FREQ <= 0.0) begin : g_bad_freq
        $error("pll_clk_gen: CLKIN_FREQ must be positive");
    end
    if (DIV < 1 || DIV > MAX_DIV) begin : g_bad_div
        $error("pll_clk_gen: DIV=%0d outside 1..%0d", DIV, MAX_DIV);
    end
    if (DIV > 1 && (HIGH_CYCLES < 1 || HIGH_CYCLES > DIV - 1))
    begin : g_bad_high
        $error("pll_clk_gen: HIGH_CYCLES=%0d outside 1..%0d",
               HIGH_CYCLES, DIV - 1);
    end
    if (PHASE < 0 || PHASE > DIV - 1) begin : g_bad_phase
        $error("pll_clk_gen: PHASE=%0d outside 0..%0d", PHASE, DIV - 1);
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > MAX_LOCK_CYCLES)
    begin : g_bad_lock
        $error("pll_clk_gen: LOCK_CYCLES=%0d outside 1..%0d",
               LOCK_CYCLES, MAX_LOCK_CYCLES);
    end

    pll_lock_det #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock_det (
        .clk_i (clkin1),
        .rst_ni(rst_n),
        .lock_o(lock)
    );

    if (DIV == 1) begin : g_bypass
        // Undivided: gate the reference so nothing leaks before lock.
        assign clkout0 = clkin1 & lock;
    end else begin : g_div
        localparam int CW = width_of(DIV);
        localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
        localparam logic [CW-1:0] HIGH_C  = CW'(HIGH_CYCLES);
        localparam logic [CW-1:0] PHASE_C = CW'(PHASE);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          clkout_q;
        logic          clkout_d;

        // Before lock the divider parks at PHASE with the output low.
        always_comb begin
            cnt_d    = cnt_q;
            clkout_d = clkout_q;
            if (lock) begin
                clkout_d = (cnt_q < HIGH_C);
                cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clkin1) begin
            if (!rst_n) begin
                cnt_q    <= PHASE_C;
                clkout_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                clkout_q <= clkout_d;
            end
        end

        assign clkout0 = clkout_q;
    end

endmodule

// File: tb/tb_pll_clk_gen.sv
// tb_pll_clk_gen: four generator configurations driven by one shared
// random reset stream, scoreboarded against an edge-count reference model.
module tb_pll_clk_gen;

    localparam int N = 4;
    localparam int P_DIV  [N] = '{2, 5, 4, 1};
    localparam int P_HIGH [N] = '{1, 2, 2, 0};
    localparam int P_PH   [N] = '{0, 0, 3, 0};
    localparam int P_LC   [N] = '{256, 16, 9, 1};

    typedef struct packed {
        logic [N-1:0] lock;
        logic [N-1:0] clk;
    } exp_t;

    logic         clkin1 = 1'b0;
    logic         rst_n  = 1'b0;
    logic [N-1:0] lock;
    logic [N-1:0] clkout;

    exp_t q[$];
    int   since   = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    bit   started = 1'b0;

    logic s1 = 1'b0;
    logic s2 = 1'b0;
    logic s3 = 1'b0;
    logic fell = 1'b0;
    bit   win = 1'b0;

    always #5 clkin1 = ~clkin1;

    pll_clk_gen u_def (
        .clkin1(clkin1), .rst_n(rst_n),
        .clkout0(clkout[0]), .lock(lock[0])
    );

    pll_clk_gen #(
        .DIV(5), .HIGH_CYCLES(2), .PHASE(0), .LOCK_CYCLES(16)
    ) u_odd (
        .clkin1(clkin1), .rst_n(rst_n),
        .clkout0(clkout[1]), .lock(lock[1])
    );

    pll_clk_gen #(
        .DIV(4), .PHASE(3), .LOCK_CYCLES(9)
    ) u_ph (
        .clkin1(clkin1), .rst_n(rst_n),
        .clkout0(clkout[2]), .lock(lock[2])
    );

    pll_clk_gen #(
        .DIV(1), .LOCK_CYCLES(1)
    ) u_byp (
        .clkin1(clkin1), .rst_n(rst_n),
        .clkout0(clkout[3]), .lock(lock[3])
    );

    // Synchronized falling-edge detector on the default instance's lock.
    always @(posedge clkin1) begin
        s1 <= lock[0];
        s2 <= s1;
        s3 <= s2;
        if (win && s3 && !s2) fell <= 1'b1;
    end

    task automatic check(input string nm, input logic act,
                         input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // s = rising edges with rst_n=1 since the last reset edge.
    // Lock holds from edge LC; run update k happens at edge LC+k and
    // shows the divider position (PHASE+k-1) mod DIV.
    function automatic exp_t predict(input int s);
        exp_t e;
        int   k;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.lock[i] = (s >= P_LC[i]);
            if (P_DIV[i] == 1) begin
                e.clk[i] = e.lock[i];
            end else if (s > P_LC[i]) begin
                k = s - P_LC[i];
                e.clk[i] = (((P_PH[i] + k - 1) % P_DIV[i]) < P_HIGH[i]);
            end
        end
        return e;
    endfunction

    task automatic drive(input logic r);
        @(negedge clkin1);
        rst_n = r;
        since = r ? since + 1 : 0;
        q.push_back(predict(since));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clkin1);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                started = 1'b1;
                for (int i = 0; i < N; i++) begin
                    check($sformatf("lock%0d", i), lock[i], e.lock[i]);
                    check($sformatf("clkout%0d", i), clkout[i], e.clk[i]);
                end
            end
        end
    end

    initial begin : low_phase
        forever begin
            @(negedge clkin1);
            #1;
            if (started) check("byp_low", clkout[3], 1'b0);
        end
    end

    initial begin : stim
        int n;
        repeat (4) drive(1'b0);
        repeat (260) drive(1'b1);
        win = 1'b1;
        repeat (1350) drive(1'b1);
        check("sticky_fall", fell, 1'b0);
        win = 1'b0;

        drive(1'b0);
        repeat (270) drive(1'b1);

        for (int t = 0; t < 10; t++) begin
            repeat ($urandom_range(1, 3)) drive(1'b0);
            n = $urandom_range(5, 400);
            for (int j = 0; j < n; j++) begin
                drive(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
            end
        end

        for (int w = 0; w < 10; w++) begin
            if (q.size() == 0) break;
            @(posedge clkin1);
            #2;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
